// File: rtl/arcade_gear_shifter.sv
// Multi-player gear-shift input processor: button edges -> registered gear index per player.
// Optional per-player shift lockout enabled by defining GEAR_SHIFT_DEBOUNCE_EN.
module arcade_gear_shifter #(
    parameter int PLAYERS      = 3,
    parameter int GEARS        = 5,
    parameter int GW           = 3,
    parameter int MODE         = 0,
    parameter int WRAP         = 0,
    parameter int DEBOUNCE_CYC = 4096
) (
    input  logic                  clock_40,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PLAYERS-1:0]    btn_up,
    input  logic [PLAYERS-1:0]    btn_down,
    input  logic [PLAYERS-1:0]    btn_home,
    output logic [PLAYERS*GW-1:0] gear,
    output logic [PLAYERS-1:0]    gear_chg
);
    localparam logic [GW-1:0] TOP = GW'(GEARS - 1);

    logic [PLAYERS-1:0] up_prev_q, dn_prev_q;
    logic [PLAYERS-1:0] up_ev, dn_ev;

    // History resets high so a button held through reset release is not an edge.
    always_ff @(posedge clock_40) begin
        if (reset) begin
            up_prev_q <= '1;
            dn_prev_q <= '1;
        end else begin
            up_prev_q <= btn_up;
            dn_prev_q <= btn_down;
        end
    end

    assign up_ev = btn_up & ~up_prev_q;
    assign dn_ev = btn_down & ~dn_prev_q;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [GW-1:0] gear_q, gear_d, step_d;
        logic          chg_q;
        logic          locked;

        always_comb begin
            step_d = gear_q;
            if (MODE == 1) begin
                if (up_ev[p]) step_d = (gear_q == '0) ? GW'(1) : '0;
            end else if (up_ev[p] && !dn_ev[p]) begin
                if (gear_q == TOP) step_d = (WRAP != 0) ? '0 : TOP;
                else               step_d = gear_q + GW'(1);
            end else if (dn_ev[p] && !up_ev[p]) begin
                if (gear_q == '0) step_d = (WRAP != 0) ? TOP : '0;
                else              step_d = gear_q - GW'(1);
            end
        end

        always_comb begin
            gear_d = gear_q;
            if (enable) begin
                if (btn_home[p]) gear_d = '0;
                else if (!locked) gear_d = step_d;
            end
        end

`ifdef GEAR_SHIFT_DEBOUNCE_EN
        localparam int LW = $clog2(DEBOUNCE_CYC + 1);
        logic [LW-1:0] lock_q;

        assign locked = (lock_q != '0);

        // Only a shift that actually moved the gear arms the lockout.
        always_ff @(posedge clock_40) begin
            if (reset)                                        lock_q <= '0;
            else if (enable && btn_home[p])                   lock_q <= '0;
            else if (enable && !locked && (step_d != gear_q)) lock_q <= LW'(DEBOUNCE_CYC);
            else if (locked)                                  lock_q <= lock_q - LW'(1);
        end
`else
        assign locked = 1'b0;
`endif

        always_ff @(posedge clock_40) begin
            if (reset) begin
                gear_q <= '0;
                chg_q  <= 1'b0;
            end else begin
                gear_q <= gear_d;
                chg_q  <= (gear_d != gear_q);
            end
        end

        assign gear[p*GW +: GW] = gear_q;
        assign gear_chg[p]      = chg_q;
    end

endmodule

// File: tb/tb_arcade_gear_shifter.sv
// Bench for arcade_gear_shifter: three configurations (saturate, wrap, toggle) driven
// in parallel, directed scenarios plus random traffic against an arithmetic model.
module tb_arcade_gear_shifter;
    localparam int P  = 3;
    localparam int G  = 5;
    localparam int GW = 3;
    localparam int DC = 16;
`ifdef GEAR_SHIFT_DEBOUNCE_EN
    localparam int GAP = 20;
`else
    localparam int GAP = 1;
`endif

    logic clk = 1'b0;
    logic rst, en;
    logic [P-1:0] up, dn, hm;
    logic [P*GW-1:0] g0, g1, g2;
    logic [P-1:0] c0, c1, c2;

    always #5 clk = ~clk;

    arcade_gear_shifter #(.PLAYERS(P), .GEARS(G), .GW(GW), .MODE(0), .WRAP(0), .DEBOUNCE_CYC(DC)) u_sat (
        .clock_40(clk), .reset(rst), .enable(en), .btn_up(up), .btn_down(dn),
        .btn_home(hm), .gear(g0), .gear_chg(c0));
    arcade_gear_shifter #(.PLAYERS(P), .GEARS(G), .GW(GW), .MODE(0), .WRAP(1), .DEBOUNCE_CYC(DC)) u_wrap (
        .clock_40(clk), .reset(rst), .enable(en), .btn_up(up), .btn_down(dn),
        .btn_home(hm), .gear(g1), .gear_chg(c1));
    arcade_gear_shifter #(.PLAYERS(P), .GEARS(G), .GW(GW), .MODE(1), .WRAP(0), .DEBOUNCE_CYC(DC)) u_tog (
        .clock_40(clk), .reset(rst), .enable(en), .btn_up(up), .btn_down(dn),
        .btn_home(hm), .gear(g2), .gear_chg(c2));

    int errors = 0;
    int checks = 0;

    // Model state: instance 0 saturating, 1 wrapping, 2 toggle.
    int mg[3][P];
    bit mc[3][P];
    int ml[3][P];
    bit pu[P], pd[P];

    function automatic logic [GW-1:0] dut_g(int i, int p);
        case (i)
            0:       return g0[p*GW +: GW];
            1:       return g1[p*GW +: GW];
            default: return g2[p*GW +: GW];
        endcase
    endfunction

    function automatic logic dut_c(int i, int p);
        case (i)
            0:       return c0[p];
            1:       return c1[p];
            default: return c2[p];
        endcase
    endfunction

    // Advance the model with the current inputs, then clock the DUTs.
    task automatic step();
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < P; p++) begin
                int old = mg[i][p];
                int nw  = old;
                int lk  = ml[i][p];
                bit ue  = up[p] && !pu[p];
                bit de  = dn[p] && !pd[p];
                bit open;
                if (rst) begin
                    nw = 0;
                    lk = 0;
                end else begin
`ifdef GEAR_SHIFT_DEBOUNCE_EN
                    open = (lk == 0);
`else
                    open = 1'b1;
`endif
                    if (lk > 0) lk--;
                    if (en) begin
                        if (hm[p]) begin
                            nw = 0;
                            lk = 0;
                        end else if (open) begin
                            if (i == 2) begin
                                if (ue) nw = 1 - old;
                            end else if (ue != de) begin
                                int d = ue ? 1 : -1;
                                if (i == 1) nw = (old + d + G) % G;
                                else if (old + d < 0) nw = 0;
                                else if (old + d > G - 1) nw = G - 1;
                                else nw = old + d;
                            end
                            if (nw != old) lk = DC;
                        end
                    end
                end
                mc[i][p] = !rst && (nw != old);
                mg[i][p] = nw;
                ml[i][p] = lk;
            end
        end
        for (int p = 0; p < P; p++) begin
            pu[p] = rst ? 1'b1 : up[p];
            pd[p] = rst ? 1'b1 : dn[p];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        up = '0;
        dn = '0;
        repeat (GAP) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; up = '0; dn = '0; hm = '0; en = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; up = '0; dn = '0; hm = '0;
        step(); step();
        for (int i = 0; i < 3; i++)
            for (int p = 0; p < P; p++) begin
                checks++;
                if (dut_g(i, p) !== '0 || dut_c(i, p) !== 1'b0) begin
                    errors++;
                    $display("FAIL reset i%0d p%0d: gear=%0d chg=%0b want 0/0", i, p, dut_g(i, p), dut_c(i, p));
                end
            end
        rst = 1'b0;
        step();
    endtask

    task automatic test_seq_sat();
        int exp_g[6] = '{1, 2, 3, 4, 4, 4};
        int strobes = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            up[0] = 1'b1;
            step();
            if (c0[0] === 1'b1) strobes++;
            checks++;
            if (dut_g(0, 0) !== GW'(exp_g[k])) begin
                errors++;
                $display("FAIL seq_sat press%0d: gear=%0d want %0d", k, dut_g(0, 0), exp_g[k]);
            end
            release_all();
        end
        checks++;
        if (strobes != 4) begin
            errors++;
            $display("FAIL seq_sat strobes: got %0d want 4", strobes);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        dn[0] = 1'b1;
        step();
        checks++;
        if (dut_g(1, 0) !== GW'(4) || c1[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_down: gear=%0d chg=%0b want 4/1", dut_g(1, 0), c1[0]);
        end
        release_all();
        up[0] = 1'b1;
        step();
        checks++;
        if (dut_g(1, 0) !== GW'(0) || c1[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up: gear=%0d chg=%0b want 0/1", dut_g(1, 0), c1[0]);
        end
        release_all();
    endtask

    task automatic test_conflict_home();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            up[0] = 1'b1;
            step();
            release_all();
        end
        up[0] = 1'b1;
        dn[0] = 1'b1;
        step();
        checks++;
        if (dut_g(0, 0) !== GW'(3) || c0[0] !== 1'b0) begin
            errors++;
            $display("FAIL up_down_same: gear=%0d chg=%0b want 3/0", dut_g(0, 0), c0[0]);
        end
        release_all();
        hm[0] = 1'b1;
        step();
        checks++;
        if (dut_g(0, 0) !== GW'(0) || c0[0] !== 1'b1) begin
            errors++;
            $display("FAIL home: gear=%0d chg=%0b want 0/1", dut_g(0, 0), c0[0]);
        end
        for (int k = 0; k < 2; k++) begin
            up[0] = 1'b1;
            step();
            checks++;
            if (dut_g(0, 0) !== GW'(0) || c0[0] !== 1'b0) begin
                errors++;
                $display("FAIL home_held_up%0d: gear=%0d chg=%0b want 0/0", k, dut_g(0, 0), c0[0]);
            end
            up[0] = 1'b0;
            step();
        end
        hm[0] = 1'b0;
        step();
    endtask

    task automatic test_held_reset();
        rst = 1'b1; up = '0; dn = '0; hm = '0; en = 1'b1;
        up[0] = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (dut_g(0, 0) !== GW'(0) || c0[0] !== 1'b0) begin
            errors++;
            $display("FAIL held_reset: gear=%0d chg=%0b want 0/0", dut_g(0, 0), c0[0]);
        end
        up[0] = 1'b0;
        step();
        up[0] = 1'b1;
        step();
        checks++;
        if (dut_g(0, 0) !== GW'(1) || c0[0] !== 1'b1) begin
            errors++;
            $display("FAIL held_reset_repress: gear=%0d chg=%0b want 1/1", dut_g(0, 0), c0[0]);
        end
        release_all();
    endtask

    task automatic test_toggle();
        int exp_g[3] = '{1, 0, 1};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            up[1] = 1'b1;
            step();
            checks++;
            if (dut_g(2, 1) !== GW'(exp_g[k]) || c2[1] !== 1'b1) begin
                errors++;
                $display("FAIL toggle_up%0d: gear=%0d chg=%0b want %0d/1", k, dut_g(2, 1), c2[1], exp_g[k]);
            end
            release_all();
        end
        for (int k = 0; k < 2; k++) begin
            dn[1] = 1'b1;
            step();
            checks++;
            if (dut_g(2, 1) !== GW'(1) || c2[1] !== 1'b0) begin
                errors++;
                $display("FAIL toggle_down%0d: gear=%0d chg=%0b want 1/0", k, dut_g(2, 1), c2[1]);
            end
            release_all();
        end
        en = 1'b0;
        up[1] = 1'b1;
        step();
        en = 1'b1;
        up[1] = 1'b0;
        step();
        checks++;
        if (dut_g(2, 1) !== GW'(1) || c2[1] !== 1'b0) begin
            errors++;
            $display("FAIL toggle_disabled: gear=%0d chg=%0b want 1/0", dut_g(2, 1), c2[1]);
        end
    endtask

`ifdef GEAR_SHIFT_DEBOUNCE_EN
    task automatic test_debounce();
        do_reset();
        up[2] = 1'b1;
        step();
        up[2] = 1'b0;
        repeat (4) step();
        up[2] = 1'b1;
        step();
        checks++;
        if (dut_g(0, 2) !== GW'(1) || c0[2] !== 1'b0) begin
            errors++;
            $display("FAIL debounce_drop: gear=%0d chg=%0b want 1/0", dut_g(0, 2), c0[2]);
        end
        up[2] = 1'b0;
        repeat (14) step();
        up[2] = 1'b1;
        step();
        checks++;
        if (dut_g(0, 2) !== GW'(2) || c0[2] !== 1'b1) begin
            errors++;
            $display("FAIL debounce_accept: gear=%0d chg=%0b want 2/1", dut_g(0, 2), c0[2]);
        end
        up[2] = 1'b0;
        hm[2] = 1'b1;
        step();
        checks++;
        if (dut_g(0, 2) !== GW'(0) || c0[2] !== 1'b1) begin
            errors++;
            $display("FAIL debounce_home: gear=%0d chg=%0b want 0/1", dut_g(0, 2), c0[2]);
        end
        hm[2] = 1'b0;
        step();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 7) != 0);
            up  = P'($urandom);
            dn  = P'($urandom);
            for (int p = 0; p < P; p++) hm[p] = ($urandom_range(0, 9) == 0);
            step();
            for (int i = 0; i < 3; i++)
                for (int p = 0; p < P; p++) begin
                    checks++;
                    if (dut_g(i, p) !== GW'(mg[i][p]) || dut_c(i, p) !== mc[i][p]) begin
                        errors++;
                        $display("FAIL random n%0d i%0d p%0d: gear=%0d chg=%0b want %0d/%0b",
                                 n, i, p, dut_g(i, p), dut_c(i, p), mg[i][p], mc[i][p]);
                    end
                end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; up = '0; dn = '0; hm = '0;
        for (int i = 0; i < 3; i++)
            for (int p = 0; p < P; p++) begin
                mg[i][p] = 0; mc[i][p] = 1'b0; ml[i][p] = 0;
            end
        test_reset();
        test_seq_sat();
        test_wrap();
        test_conflict_home();
        test_held_reset();
        test_toggle();
`ifdef GEAR_SHIFT_DEBOUNCE_EN
        test_debounce();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
